// File: rtl/if_id_stall_pipe_pkg.sv
// Shared constants, IF/ID payload type and PC alignment helper for the fetch stage.
// Optional feature macro: IF_ID_PERF_CNT_EN (perf counters on the interface).
package if_id_stall_pipe_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned STALL_CNT_W = 8;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_id_stall_pipe_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction memory and IF/ID outputs.
// Perf counter signals exist only when IF_ID_PERF_CNT_EN is defined.
interface if_id_stall_pipe_if;
  logic        Hazard_PC_Hold;
  logic        Hazard_IFID_Hold;
  logic        Hazard_Ctrl_Zero;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic [31:0] Instruction;
  logic [31:0] Instr_Addr;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PC_Plus4;
  logic        IFID_Valid;
  logic        IDEX_Bubble;
  logic        Stall_Timeout;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] Perf_Stall_Cnt;
  logic [31:0] Perf_Flush_Cnt;
  logic [31:0] Perf_Fetch_Cnt;
`endif

  modport master (
    output Hazard_PC_Hold, Hazard_IFID_Hold, Hazard_Ctrl_Zero,
    output Redirect, Redirect_Target, Instruction,
    input  Instr_Addr, IFID_Instruction, IFID_PC_Plus4, IFID_Valid,
    input  IDEX_Bubble, Stall_Timeout
`ifdef IF_ID_PERF_CNT_EN
    , input Perf_Stall_Cnt, Perf_Flush_Cnt, Perf_Fetch_Cnt
`endif
  );

  modport slave (
    input  Hazard_PC_Hold, Hazard_IFID_Hold, Hazard_Ctrl_Zero,
    input  Redirect, Redirect_Target, Instruction,
    output Instr_Addr, IFID_Instruction, IFID_PC_Plus4, IFID_Valid,
    output IDEX_Bubble, Stall_Timeout
`ifdef IF_ID_PERF_CNT_EN
    , output Perf_Stall_Cnt, Perf_Flush_Cnt, Perf_Fetch_Cnt
`endif
  );
endinterface

// File: rtl/if_id_stall_pipe_pc_reg.sv
// Program counter: redirect beats hold beats increment; redirect targets are word-aligned.
module if_id_stall_pipe_pc_reg
  import if_id_stall_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        hold,
  output logic [31:0] pc
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= align_pc(redirect_target);
    end else if (!hold) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/if_id_stall_pipe.sv
// Fetch stage: PC, IF/ID register with hold/flush, stall watchdog.
// Define IF_ID_PERF_CNT_EN to add saturating stall/flush/fetch perf counters.
module if_id_stall_pipe
  import if_id_stall_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  if_id_stall_pipe_if.slave  bus
);

  logic [31:0]            pc;
  ifid_t                  ifid_q;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [STALL_CNT_W-1:0] stall_cnt_nxt;
  logic                   timeout_q;
  logic                   stall_edge;
  logic                   fetch_edge;

  if_id_stall_pipe_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .redirect        (bus.Redirect),
    .redirect_target (bus.Redirect_Target),
    .hold            (bus.Hazard_PC_Hold),
    .pc              (pc)
  );

  assign stall_edge = bus.Hazard_PC_Hold & ~bus.Redirect;
  assign fetch_edge = ~bus.Redirect & ~bus.Hazard_IFID_Hold;

  // IF/ID register: flush on redirect wins over hold
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ifid_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (bus.Redirect) begin
      ifid_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (!bus.Hazard_IFID_Hold) begin
      ifid_q <= '{instr: bus.Instruction, pc_plus4: pc + PC_INC, valid: 1'b1};
    end
  end

  // Watchdog: consecutive PC-hold edges, saturating; timeout is sticky until reset
  always_comb begin
    stall_cnt_nxt = '0;
    if (stall_edge) begin
      stall_cnt_nxt = (stall_cnt == '1) ? stall_cnt : stall_cnt + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == STALL_CNT_W'(MAX_STALL)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.Instr_Addr       = pc;
  assign bus.IFID_Instruction = ifid_q.instr;
  assign bus.IFID_PC_Plus4    = ifid_q.pc_plus4;
  assign bus.IFID_Valid       = ifid_q.valid;
  assign bus.IDEX_Bubble      = bus.Hazard_Ctrl_Zero & ifid_q.valid;
  assign bus.Stall_Timeout    = timeout_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_fetch_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_fetch_q <= '0;
    end else begin
      if (stall_edge   && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
      if (bus.Redirect && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 32'd1;
      if (fetch_edge   && perf_fetch_q != '1) perf_fetch_q <= perf_fetch_q + 32'd1;
    end
  end

  assign bus.Perf_Stall_Cnt = perf_stall_q;
  assign bus.Perf_Flush_Cnt = perf_flush_q;
  assign bus.Perf_Fetch_Cnt = perf_fetch_q;
`else
  logic unused_fetch_edge;
  assign unused_fetch_edge = fetch_edge;
`endif

endmodule

// File: tb/tb_if_id_stall_pipe.sv
// Self-checking bench for if_id_stall_pipe: directed scenarios plus random stimulus vs a cycle model.
module tb_if_id_stall_pipe;

  localparam int unsigned MAX_STALL = 16;

  logic Clk;
  logic Rst_n;
  if_id_stall_pipe_if bus ();

  if_id_stall_pipe #(.RESET_PC(32'h0), .MAX_STALL(MAX_STALL)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [31:0] mem [64];
  assign bus.Instruction = mem[bus.Instr_Addr[7:2]];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: what the fetch stage should hold after each edge
  logic [31:0] m_pc, m_ii, m_ip4;
  logic        m_iv, m_to;
  int          m_cnt;
  longint      m_ps, m_pf, m_pfe;

  function automatic logic [98:0] dut_vec();
    return {bus.Instr_Addr, bus.IFID_Instruction, bus.IFID_PC_Plus4,
            bus.IFID_Valid, bus.IDEX_Bubble, bus.Stall_Timeout};
  endfunction

  function automatic logic [98:0] model_vec();
    return {m_pc, m_ii, m_ip4, m_iv, bus.Hazard_Ctrl_Zero & m_iv, m_to};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ii = 32'h0; m_ip4 = 32'h0; m_iv = 1'b0; m_to = 1'b0;
    m_cnt = 0; m_ps = 0; m_pf = 0; m_pfe = 0;
  endtask

  task automatic set_inputs(input logic ph, input logic ih, input logic cz,
                            input logic rd, input logic [31:0] tgt);
    bus.Hazard_PC_Hold   = ph;
    bus.Hazard_IFID_Hold = ih;
    bus.Hazard_Ctrl_Zero = cz;
    bus.Redirect         = rd;
    bus.Redirect_Target  = tgt;
  endtask

  // Apply inputs for one edge, advance the reference, settle 1 time unit past the edge
  task automatic step(input logic ph, input logic ih, input logic cz,
                      input logic rd, input logic [31:0] tgt);
    logic [31:0] fetched;
    logic [31:0] old_pc;
    set_inputs(ph, ih, cz, rd, tgt);
    old_pc  = m_pc;
    fetched = mem[old_pc[7:2]];
    @(posedge Clk);
    if (rd)       m_pc = {tgt[31:2], 2'b00};
    else if (!ph) m_pc = old_pc + 32'd4;
    if (rd) begin
      m_ii = 32'h0; m_ip4 = 32'h0; m_iv = 1'b0;
    end else if (!ih) begin
      m_ii = fetched; m_ip4 = old_pc + 32'd4; m_iv = 1'b1;
    end
    if (ph && !rd) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    else           m_cnt = 0;
    if (m_cnt == int'(MAX_STALL)) m_to = 1'b1;
    if (ph && !rd && m_ps < 64'hFFFF_FFFF) m_ps++;
    if (rd && m_pf < 64'hFFFF_FFFF) m_pf++;
    if (!rd && !ih && m_pfe < 64'hFFFF_FFFF) m_pfe++;
    #1;
  endtask

  task automatic do_reset();
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    set_inputs(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    Rst_n = 1'b0;
    #12;
    n_cmp++;
    if (dut_vec() !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", dut_vec(),
               {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    end
    do_reset();
  endtask

  task automatic test_free_run();
    logic [31:0] w0;
    w0 = mem[0];
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (dut_vec() !== {32'd4, w0, 32'd4, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL free_run_first: got %h want %h", dut_vec(), {32'd4, w0, 32'd4, 1'b1, 1'b0, 1'b0});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.Instr_Addr !== 32'd8 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL free_run_second: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_hold();
    logic [31:0] w1;
    w1 = mem[1];
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (dut_vec() !== {32'd8, w1, 32'd8, 1'b1, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got %h want %h", i, dut_vec(), {32'd8, w1, 32'd8, 1'b1, 1'b1, 1'b0});
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.Instr_Addr !== 32'd12 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL hold_release: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_redirect();
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    n_cmp++;
    if (dut_vec() !== {32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL redirect_flush: got %h want %h", dut_vec(), {32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.Instr_Addr !== 32'h104 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL redirect_resume: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wtop;
    wtop = mem[63];
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (dut_vec() !== {32'h0, wtop, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h want %h", dut_vec(), {32'h0, wtop, 32'h0, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < int'(MAX_STALL) - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.Stall_Timeout !== 1'b0 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL watchdog_short: got %h want %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < int'(MAX_STALL) - 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.Stall_Timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_before_limit: got %b want 0", bus.Stall_Timeout);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.Stall_Timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL watchdog_at_limit: got %b want 1", bus.Stall_Timeout);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    n_cmp++;
    if (bus.Stall_Timeout !== 1'b1 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL watchdog_sticky: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #2 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", dut_vec(), {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    end
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL post_reset_redirect: got %h want %h", dut_vec(), model_vec());
    end
`ifdef IF_ID_PERF_CNT_EN
    n_cmp++;
    if (bus.Perf_Stall_Cnt !== 32'd3 || bus.Perf_Flush_Cnt !== 32'd1 || bus.Perf_Fetch_Cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_counts: got %0d/%0d/%0d want 3/1/0",
               bus.Perf_Stall_Cnt, bus.Perf_Flush_Cnt, bus.Perf_Fetch_Cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic ph, ih, cz, rd;
    logic [31:0] tgt;
    int len;
    for (int b = 0; b < 30; b++) begin
      len = int'($urandom_range(1, 24));
      ph  = ($urandom % 2) == 0;
      for (int i = 0; i < len; i++) begin
        ih  = ph ? (($urandom % 4) != 0) : (($urandom % 6) == 0);
        cz  = ($urandom % 2) == 0;
        rd  = ($urandom % 20) == 0;
        tgt = $urandom;
        step(ph, ih, cz, rd, tgt);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
          n_fail++;
          $display("FAIL random_b%0d_i%0d: got %h want %h", b, i, dut_vec(), model_vec());
        end
`ifdef IF_ID_PERF_CNT_EN
        n_cmp++;
        if ({bus.Perf_Stall_Cnt, bus.Perf_Flush_Cnt, bus.Perf_Fetch_Cnt} !==
            {m_ps[31:0], m_pf[31:0], m_pfe[31:0]}) begin
          n_fail++;
          $display("FAIL random_perf_b%0d_i%0d: got %0d/%0d/%0d want %0d/%0d/%0d", b, i,
                   bus.Perf_Stall_Cnt, bus.Perf_Flush_Cnt, bus.Perf_Fetch_Cnt, m_ps, m_pf, m_pfe);
        end
`endif
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    model_reset();
    test_reset();
    test_free_run();
    test_hold();
    test_redirect();
    test_wrap();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stall_pipe.md
Name: if_id_stall_pipe

Overview:
- Fetch-side consumer of the hazard unit's stall outputs.
- Owns the program counter and the IF/ID pipeline register.
- Applies the hazard unit's PC hold, IF/ID hold and control-zero requests, plus branch/jump redirect-and-flush from later stages.
- Sits between instruction memory (combinational read) and the ID stage. Adds a stall watchdog so a stuck hazard condition is flagged.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_STALL, 16, consecutive hold cycles after which Stall_Timeout sets (legal range 1..255).

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Hazard_PC_Hold  in  1  1 = hold PC this cycle (from hazard unit)
- Hazard_IFID_Hold  in  1  1 = hold IF/ID register this cycle
- Hazard_Ctrl_Zero  in  1  1 = ID stage must issue a bubble
- Redirect  in  1  taken branch/jump from a later stage
- Redirect_Target  in  32  new PC when Redirect=1
- Instruction  in  32  instruction memory read data for Instr_Addr
- Instr_Addr  out  32  current PC, drives instruction memory
- IFID_Instruction  out  32  registered instruction to ID
- IFID_PC_Plus4  out  32  registered PC+4 of that instruction
- IFID_Valid  out  1  IF/ID holds a real instruction
- IDEX_Bubble  out  1  combinational: Hazard_Ctrl_Zero & IFID_Valid
- Stall_Timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (Rst_n=0, async):
  - PC=RESET_PC.
  - IFID_Instruction=32'h0 (NOP), IFID_PC_Plus4=0, IFID_Valid=0.
  - Stall counter=0, Stall_Timeout=0, perf counters=0.
  - Reset mid-hold or mid-redirect discards all state. First fetch after deassert is at RESET_PC.
- PC update, per rising edge, in priority order:
  - Redirect=1: PC <= {Redirect_Target[31:2],2'b00}. Misaligned low bits are forced to 0.
  - Else Hazard_PC_Hold=1: PC unchanged.
  - Else: PC <= PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update, per rising edge, in priority order:
  - Redirect=1: flush. Instruction <= NOP, PC_Plus4 <= 0, Valid <= 0. Flush overrides hold.
  - Else Hazard_IFID_Hold=1: all IF/ID fields unchanged.
  - Else: Instruction <= Instruction input, PC_Plus4 <= PC+4, Valid <= 1.
- Latency: an instruction at address A appears on the IF/ID outputs one cycle after Instr_Addr=A. The redirect penalty is one flushed slot.
- Mismatched holds: PC_Hold=1 with IFID_Hold=0 is legal and is not corrected by this block. IF/ID reloads with the re-fetched instruction (duplicate).
- IDEX_Bubble is purely combinational. It never asserts while IFID_Valid=0.
- Watchdog:
  - The 8-bit counter increments on each edge where Hazard_PC_Hold=1 and Redirect=0.
  - It clears to 0 on any other edge.
  - It saturates at 255.
  - When the counter reaches MAX_STALL, Stall_Timeout sets on that edge. It stays set until reset.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, adds three outputs:
  - Perf_Stall_Cnt [31:0]: counts edges with Hazard_PC_Hold=1 and Redirect=0.
  - Perf_Flush_Cnt [31:0]: counts edges with Redirect=1.
  - Perf_Fetch_Cnt [31:0]: counts edges where IF/ID loads a valid instruction.
- All three saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package:
  - NOP_INSTR = 32'h0
  - PC_INC = 32'd4
  - PC_ALIGN_MASK = 32'hFFFF_FFFC
  - Default RESET_PC
- One natural sub-module: pc_reg. It holds the PC register with redirect/hold/increment priority and alignment.
- The IF/ID register, watchdog and perf counters stay in the top module.

Test Plan:
- Reset, then free run with RESET_PC=0 -> Instr_Addr goes 0,4,8. Cycle after Instr_Addr=0: IFID_Instruction=mem[0], IFID_PC_Plus4=4, IFID_Valid=1.
- Assert PC_Hold+IFID_Hold+Ctrl_Zero for 2 cycles at PC=8 -> Instr_Addr holds 8, IF/ID holds the word from addr 4, IDEX_Bubble=1 both cycles. Fetch resumes to 12 after release.
- Redirect=1 with target 32'h0000_0103 while PC_Hold=1 -> next Instr_Addr=32'h100, IFID_Valid=0, IFID_Instruction=0, IDEX_Bubble=0.
- Free run with PC forced near the top: PC=32'hFFFF_FFFC with no hold -> next Instr_Addr=0.
- Hold PC_Hold=1 for MAX_STALL=16 cycles -> Stall_Timeout rises on the 16th edge and stays 1 after hold drops. Separately, 15 holds then 1 release -> Stall_Timeout stays 0.
- Drop Rst_n asynchronously mid-hold, then with IF_ID_PERF_CNT_EN also run 3 stalls + 1 redirect:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - Perf_Stall_Cnt=3, Perf_Flush_Cnt=1.
